cpu_mmio_bridge: RTL and testbench

Parametrised CPU-side memory-mapped I/O bridge. It decodes each CPU bus access against `NUM_CH` base/mask windows and drives a registered register-interface strobe to the winning peripheral, such as the PPU at $2000-$3FFF (8-byte mirror). It holds the CPU with a ready handshake until the peripheral acknowledges or a timeout expires. Unmapped or timed-out reads return NES open-bus data, which is the last value seen on the data bus.

---
 rtl/cpu_mmio_bridge.sv | 171 +++++++++++++++++
 tb/tb_cpu_mmio_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mmio_bridge.sv
// ---------------------------------------------------------------------------
// cpu_mmio_bridge
//
// CPU-side memory-mapped I/O bridge. Each CPU access is decoded against
// NUM_CH base/mask windows. The lowest-index matching channel receives a
// registered register-interface strobe. The CPU is held until that channel
// acknowledges or a wait counter expires. Unmapped and timed-out reads
// return the open-bus value, which is the last value seen on the data bus.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cpu_req               access request (sampled in IDLE only)
//   cpu_addr, cpu_r_nw    address and direction (1 = read)
//   cpu_din               CPU write data
//   cpu_dout              open-bus latch / read data
//   cpu_rdy, cpu_err      one-cycle completion pulse, timeout flag
//   ch_ncs                active-low per-channel chip selects
//   ch_sel, ch_r_nw       registered register select and direction
//   ch_d_out              registered write data to the channels
//   ch_d_in               per-channel read data (channel 0 in the LSBs)
//   ch_ack                per-channel acknowledge
// ---------------------------------------------------------------------------
module cpu_mmio_bridge #(
    parameter int                     NUM_CH  = 4,
    parameter int                     ADDR_W  = 16,
    parameter int                     DATA_W  = 8,
    parameter int                     SEL_W   = 3,
    parameter logic [NUM_CH*ADDR_W-1:0] CH_BASE = {16'h8000, 16'h6000, 16'h4000, 16'h2000},
    parameter logic [NUM_CH*ADDR_W-1:0] CH_MASK = {16'h8000, 16'hE000, 16'hFFE0, 16'hE000},
    parameter int                     TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_req,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic                     cpu_r_nw,
    input  logic [DATA_W-1:0]        cpu_din,
    output logic [DATA_W-1:0]        cpu_dout,
    output logic                     cpu_rdy,
    output logic                     cpu_err,
    output logic [NUM_CH-1:0]        ch_ncs,
    output logic [SEL_W-1:0]         ch_sel,
    output logic                     ch_r_nw,
    output logic [DATA_W-1:0]        ch_d_out,
    input  logic [NUM_CH*DATA_W-1:0] ch_d_in,
    input  logic [NUM_CH-1:0]        ch_ack
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] open_bus_reg;

    // Address decode: one comparator per window.
    logic [NUM_CH-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_decode
            assign hit[gi] = (cpu_addr & CH_MASK[gi*ADDR_W +: ADDR_W])
                             == CH_BASE[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Lowest-index match wins: scan downwards so the smallest index is
    // written last.
    logic [IDX_W-1:0] win_idx;
    logic             any_hit;

    always_comb begin
        win_idx = '0;
        any_hit = |hit;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    // Only the selected channel's ack and data are ever looked at.
    logic              sel_ack;
    logic [DATA_W-1:0] sel_data;

    assign sel_ack  = ch_ack[idx_reg];
    assign sel_data = ch_d_in[idx_reg*DATA_W +: DATA_W];

    assign cpu_dout = open_bus_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            open_bus_reg <= '0;
            cpu_rdy      <= 1'b0;
            cpu_err      <= 1'b0;
            ch_ncs       <= '1;
            ch_sel       <= '0;
            ch_r_nw      <= 1'b1;
            ch_d_out     <= '0;
        end else begin
            // Completion pulses last exactly one cycle (the DONE cycle).
            cpu_rdy <= 1'b0;
            cpu_err <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cpu_req) begin
                        if (any_hit) begin
                            idx_reg   <= win_idx;
                            cnt_reg   <= '0;
                            ch_sel    <= cpu_addr[SEL_W-1:0];
                            ch_r_nw   <= cpu_r_nw;
                            ch_d_out  <= cpu_din;
                            ch_ncs    <= ~(NUM_CH'(1) << win_idx);
                            // A write drives the data bus, so it becomes
                            // the open-bus value immediately.
                            if (!cpu_r_nw) begin
                                open_bus_reg <= cpu_din;
                            end
                            state_reg <= ACCESS;
                        end else begin
                            // Unmapped: complete at once, latch unchanged.
                            cpu_rdy   <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                end

                ACCESS: begin
                    // Ack is tested before the timeout so an ack on the
                    // last allowed cycle still completes normally.
                    if (sel_ack) begin
                        if (ch_r_nw) begin
                            open_bus_reg <= sel_data;
                        end
                        ch_ncs    <= '1;
                        cpu_rdy   <= 1'b1;
                        state_reg <= DONE;
                    end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        ch_ncs    <= '1;
                        cpu_rdy   <= 1'b1;
                        cpu_err   <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                DONE: begin
                    state_reg <= IDLE;
                end

                default: begin
                    ch_ncs    <= '1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mmio_bridge.sv
// ---------------------------------------------------------------------------
// tb_cpu_mmio_bridge
//
// Two bridge instances share clock, reset and the bus inputs but have their
// own request lines: dut0 uses the default windows, dut1 has channel 3 made
// match-all (base 0, mask 0) to exercise priority. A driver issues directed
// accesses and pushes the hand-computed expected response into a per-DUT
// queue; a negedge monitor pops and compares whenever cpu_rdy is seen.
// ---------------------------------------------------------------------------
module tb_cpu_mmio_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]        req;
    logic [15:0]       addr;
    logic              r_nw;
    logic [7:0]        din;
    logic [31:0]       d_in;
    logic [3:0]        ack;

    logic [1:0][7:0]   dout_o;
    logic [1:0]        rdy_o;
    logic [1:0]        err_o;
    logic [1:0][3:0]   ncs_o;
    logic [1:0][2:0]   sel_o;
    logic [1:0]        rnw_o;
    logic [1:0][7:0]   wd_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    cpu_mmio_bridge dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(req[0]), .cpu_addr(addr), .cpu_r_nw(r_nw), .cpu_din(din),
        .cpu_dout(dout_o[0]), .cpu_rdy(rdy_o[0]), .cpu_err(err_o[0]),
        .ch_ncs(ncs_o[0]), .ch_sel(sel_o[0]), .ch_r_nw(rnw_o[0]),
        .ch_d_out(wd_o[0]), .ch_d_in(d_in), .ch_ack(ack)
    );

    cpu_mmio_bridge #(
        .CH_BASE({16'h0000, 16'h6000, 16'h4000, 16'h2000}),
        .CH_MASK({16'h0000, 16'hE000, 16'hFFE0, 16'hE000})
    ) dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(req[1]), .cpu_addr(addr), .cpu_r_nw(r_nw), .cpu_din(din),
        .cpu_dout(dout_o[1]), .cpu_rdy(rdy_o[1]), .cpu_err(err_o[1]),
        .ch_ncs(ncs_o[1]), .ch_sel(sel_o[1]), .ch_r_nw(rnw_o[1]),
        .ch_d_out(wd_o[1]), .ch_d_in(d_in), .ch_ack(ack)
    );

    typedef struct {
        int          issue;
        logic [15:0] addr;
        logic [3:0]  ncs;
        int          low;
        logic [2:0]  sel;
        logic        rnw;
        logic [7:0]  wdata;
        logic [7:0]  dout;
        logic        err;
        int          lat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int         low_cnt[2];
    logic [3:0] seen_ncs[2];
    logic [2:0] seen_sel[2];
    logic       seen_rnw[2];
    logic [7:0] seen_wd[2];
    logic       unstable[2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            low_cnt[d]  = 0;
            seen_ncs[d] = 4'hF;
            seen_sel[d] = '0;
            seen_rnw[d] = 1'b1;
            seen_wd[d]  = '0;
            unstable[d] = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                low_cnt[d]  = 0;
                seen_ncs[d] = 4'hF;
                unstable[d] = 1'b0;
            end else begin
                if (ncs_o[d] != 4'hF) begin
                    chk("ncs_onehot", d, $countones(~ncs_o[d]), 1);
                    if (low_cnt[d] == 0) begin
                        seen_ncs[d] = ncs_o[d];
                        seen_sel[d] = sel_o[d];
                        seen_rnw[d] = rnw_o[d];
                        seen_wd[d]  = wd_o[d];
                    end else if (ncs_o[d] != seen_ncs[d] || sel_o[d] != seen_sel[d] ||
                                 rnw_o[d] != seen_rnw[d] || wd_o[d] != seen_wd[d]) begin
                        unstable[d] = 1'b1;
                    end
                    low_cnt[d]++;
                end
                if (err_o[d] && !rdy_o[d]) begin
                    chk("err_without_rdy", d, rdy_o[d], err_o[d]);
                end
                if (rdy_o[d]) begin
                    exp_t e;
                    int   have;
                    have = 0;
                    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
                    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
                    if (have == 0) begin
                        chk("unexpected_rdy", d, rdy_o[d], 0);
                    end else begin
                        chk("latency", d, cyc - e.issue, e.lat);
                        chk("cpu_err", d, err_o[d], e.err);
                        chk("cpu_dout", d, dout_o[d], e.dout);
                        chk("ncs_pattern", d, seen_ncs[d], e.ncs);
                        chk("ncs_cycles", d, low_cnt[d], e.low);
                        if (e.low > 0) begin
                            chk("ch_sel", d, seen_sel[d], e.sel);
                            chk("ch_r_nw", d, seen_rnw[d], e.rnw);
                            chk("ch_stable", d, unstable[d], 0);
                            if (!e.rnw) chk("ch_d_out", d, seen_wd[d], e.wdata);
                        end
                        $display("txn dut%0d %s addr=%04h dout=%02h err=%b lat=%0d ncs=%b",
                                 d, e.rnw ? "RD" : "WR", e.addr, dout_o[d], err_o[d],
                                 cyc - e.issue, seen_ncs[d]);
                    end
                    low_cnt[d]  = 0;
                    seen_ncs[d] = 4'hF;
                    unstable[d] = 1'b0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    // ack_dly counts ACCESS cycles before the ack (0 = ack in first ACCESS cycle).
    task automatic run(input int d, input logic [15:0] a, input logic rw, input logic [7:0] wd,
                       input int ack_ch, input int ack_dly, input int xack_ch, input int xack_dly,
                       input logic [31:0] dvec, input logic [3:0] e_ncs, input int e_low,
                       input logic [7:0] e_dout, input logic e_err, input int e_lat);
        exp_t e;
        int   got;
        @(posedge clk); #1;
        addr = a; r_nw = rw; din = wd; d_in = dvec;
        e.issue = cyc; e.addr = a; e.ncs = e_ncs; e.low = e_low; e.sel = a[2:0];
        e.rnw = rw; e.wdata = wd; e.dout = e_dout; e.err = e_err; e.lat = e_lat;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        req[d] = 1'b1;
        @(posedge clk); #1;
        req = '0;
        got = 0;
        for (int c = 1; c <= 40; c++) begin
            ack = '0;
            if (ack_ch >= 0 && c == ack_dly + 1) ack[ack_ch] = 1'b1;
            if (xack_ch >= 0 && c == xack_dly + 1) ack[xack_ch] = 1'b1;
            @(negedge clk);
            if (rdy_o[d]) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        ack = '0;
        if (got == 0) chk("completion_bound", d, got, 1);
    endtask

    initial begin
        rst = 1'b1; req = '0; addr = '0; r_nw = 1'b1; din = '0; d_in = '0; ack = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ncs", d, ncs_o[d], 4'hF);
            chk("rst_rdy", d, rdy_o[d], 0);
            chk("rst_err", d, err_o[d], 0);
            chk("rst_dout", d, dout_o[d], 0);
            chk("rst_sel", d, sel_o[d], 0);
            chk("rst_rnw", d, rnw_o[d], 1);
            chk("rst_dout_ch", d, wd_o[d], 0);
        end
        rst = 1'b0;

        // PPU mirror read, ack after 2 waits
        run(0, 16'h3FFA, 1'b1, 8'h00, 0, 2, -1, 0, 32'h0000005A, 4'b1110, 3, 8'h5A, 1'b0, 4);
        // write to $4014, zero-wait ack
        run(0, 16'h4014, 1'b0, 8'h77, 1, 0, -1, 0, 32'h00000000, 4'b1101, 1, 8'h77, 1'b0, 2);
        // timeout read: open bus holds $77
        run(0, 16'h6000, 1'b1, 8'h00, -1, 0, -1, 0, 32'h00AA0000, 4'b1011, 15, 8'h77, 1'b1, 16);
        // unmapped read
        run(0, 16'h0100, 1'b1, 8'h00, -1, 0, -1, 0, 32'h00000000, 4'b1111, 0, 8'h77, 1'b0, 1);
        // ack on the last timeout cycle wins
        run(0, 16'h6001, 1'b1, 8'h00, 2, 14, -1, 0, 32'h00C30000, 4'b1011, 15, 8'hC3, 1'b0, 16);
        // ch3 ack during ch0 access is ignored
        run(0, 16'h2005, 1'b1, 8'h00, 0, 1, 3, 0, 32'hEE000011, 4'b1110, 2, 8'h11, 1'b0, 3);

        // reset mid-ACCESS with a stale ack
        @(posedge clk); #1;
        addr = 16'h6000; r_nw = 1'b1; d_in = 32'h00990000; req[0] = 1'b1;
        @(posedge clk); #1;
        req = '0;
        @(posedge clk); #1;
        rst = 1'b1; ack[2] = 1'b1;
        #1;
        chk("midrst_ncs", 0, ncs_o[0], 4'hF);
        chk("midrst_rdy", 0, rdy_o[0], 0);
        chk("midrst_dout", 0, dout_o[0], 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_ack_rdy", 0, rdy_o[0], 0);
            chk("postrst_ncs", 0, ncs_o[0], 4'hF);
            chk("postrst_dout", 0, dout_o[0], 0);
        end
        @(posedge clk); #1;
        ack = '0;

        // open bus after reset is 0
        run(0, 16'h0100, 1'b1, 8'h00, -1, 0, -1, 0, 32'h00000000, 4'b1111, 0, 8'h00, 1'b0, 1);

        // dut1: ch0 wins over match-all ch3
        run(1, 16'h2000, 1'b1, 8'h00, 0, 0, -1, 0, 32'h3C0000A5, 4'b1110, 1, 8'hA5, 1'b0, 2);
        // dut1: otherwise-unmapped address lands on ch3
        run(1, 16'h0100, 1'b1, 8'h00, 3, 0, -1, 0, 32'h3C000000, 4'b0111, 1, 8'h3C, 1'b0, 2);
        // dut1: write to $8000 via ch3, one wait
        run(1, 16'h8000, 1'b0, 8'h96, 3, 1, -1, 0, 32'h00000000, 4'b0111, 2, 8'h96, 1'b0, 3);

        repeat (3) @(posedge clk);
        #1;
        chk("queue0_drained", 0, q0.size(), 0);
        chk("queue1_drained", 1, q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
